// File: rtl/aes_sequencer.sv
// -----------------------------------------------------------------------------
// aes_sequencer
//   Bus master that runs complete AES jobs on the register-mapped aes wrapper.
//   A job (key, key length, direction, block) arrives over a valid/ready
//   handshake. The sequencer then writes CONFIG, the key words and INIT, polls
//   STATUS until key expansion is done, writes the block and NEXT, polls until
//   the result is valid and finally reads the four result words back. The last
//   expanded key is remembered, so a job that reuses it skips key expansion.
//
// Ports
//   clk, reset_n          clock; asynchronous reset, active-high (1 = reset)
//   req_*                 job request (valid/ready), captured on acceptance
//   rsp_*                 job response (valid/ready), held stable until taken
//   flush_key             invalidate the key cache
//   busy                  high whenever a job is in flight or waiting
//   aes_*                 single-cycle accesses to the aes register port
// -----------------------------------------------------------------------------
module aes_sequencer #(
  parameter int POLL_TIMEOUT  = 1023,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [255:0] req_key,
  input  logic         req_keylen,
  input  logic         req_encdec,
  input  logic [127:0] req_block,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_result,
  output logic         rsp_timeout,
  input  logic         flush_key,
  output logic         busy,
  output logic         aes_cs,
  output logic         aes_we,
  output logic [7:0]   aes_address,
  output logic [31:0]  aes_write_data,
  input  logic [31:0]  aes_read_data
);

  typedef enum logic [3:0] {
    IDLE, CFG, KEY, INIT, SETTLE_I, POLL_I, BLK, NEXT, SETTLE_N, POLL_N, RES, RESP
  } state_t;

  // One counter serves word index, settle delay and poll count; it clears on
  // every state change, so each phase starts counting from zero.
  localparam int CNT_SPAN = ((POLL_TIMEOUT > SETTLE_CYCLES) ? POLL_TIMEOUT : SETTLE_CYCLES) + 8;
  localparam int CW       = $clog2(CNT_SPAN);
  localparam logic [CW-1:0] POLL_LAST   = CW'(POLL_TIMEOUT);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0a;
  localparam logic [7:0] ADDR_KEY0   = 8'h10;
  localparam logic [7:0] ADDR_BLOCK0 = 8'h20;
  localparam logic [7:0] ADDR_RES0   = 8'h30;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [255:0]   key_q;
  logic           keylen_q;
  logic           encdec_q;
  logic [127:0]   block_q;
  logic           cache_valid;
  logic [255:0]   cached_key;
  logic           cached_keylen;

  logic           hit;
  logic           poll_ok;
  logic           timeout;
  logic           cache_load;

  assign idx = cnt[2:0];

  // flush_key in the same cycle as the check forces a miss.
  assign hit = cache_valid && !flush_key &&
               (key_q == cached_key) && (keylen_q == cached_keylen);

  always_comb begin
    poll_ok = 1'b0;
    if (state_q == POLL_I) poll_ok = aes_read_data[0];
    if (state_q == POLL_N) poll_ok = (aes_read_data[1:0] == 2'b11);
  end

  assign timeout    = ((state_q == POLL_I) || (state_q == POLL_N)) && !poll_ok &&
                      (cnt == POLL_LAST);
  assign cache_load = (state_q == POLL_I) && poll_ok;

  // State register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of process ordering.
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_valid) state_d = CFG;
      CFG:      state_d = hit ? BLK : KEY;
      KEY:      if (idx == (keylen_q ? 3'd7 : 3'd3)) state_d = INIT;
      INIT:     state_d = (SETTLE_CYCLES == 0) ? POLL_I : SETTLE_I;
      SETTLE_I: if (cnt == SETTLE_LAST) state_d = POLL_I;
      POLL_I:   if (poll_ok) state_d = BLK;
                else if (timeout) state_d = RESP;
      BLK:      if (idx == 3'd3) state_d = NEXT;
      NEXT:     state_d = (SETTLE_CYCLES == 0) ? POLL_N : SETTLE_N;
      SETTLE_N: if (cnt == SETTLE_LAST) state_d = POLL_N;
      POLL_N:   if (poll_ok) state_d = RES;
                else if (timeout) state_d = RESP;
      RES:      if (idx == 3'd3) state_d = RESP;
      RESP:     if (rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs: bus access and handshake flags decoded from the current state.
  always_comb begin
    aes_cs         = 1'b0;
    aes_we         = 1'b0;
    aes_address    = 8'h00;
    aes_write_data = 32'h0;
    req_ready      = (state_q == IDLE);
    rsp_valid      = (state_q == RESP);
    busy           = (state_q != IDLE);
    unique case (state_q)
      CFG: begin
        aes_cs = 1'b1; aes_we = 1'b1; aes_address = ADDR_CONFIG;
        aes_write_data = {30'b0, keylen_q, encdec_q};
      end
      KEY: begin
        aes_cs = 1'b1; aes_we = 1'b1; aes_address = ADDR_KEY0 + {5'b0, idx};
        aes_write_data = key_q[8'd255 - {idx, 5'b0} -: 32];
      end
      INIT: begin
        aes_cs = 1'b1; aes_we = 1'b1; aes_address = ADDR_CTRL;
        aes_write_data = 32'h1;
      end
      BLK: begin
        aes_cs = 1'b1; aes_we = 1'b1; aes_address = ADDR_BLOCK0 + {6'b0, idx[1:0]};
        aes_write_data = block_q[7'd127 - {idx[1:0], 5'b0} -: 32];
      end
      NEXT: begin
        aes_cs = 1'b1; aes_we = 1'b1; aes_address = ADDR_CTRL;
        aes_write_data = 32'h2;
      end
      POLL_I, POLL_N: begin
        aes_cs = 1'b1; aes_address = ADDR_STATUS;
      end
      RES: begin
        aes_cs = 1'b1; aes_address = ADDR_RES0 + {6'b0, idx[1:0]};
      end
      default: ;
    endcase
  end

  // Datapath: job capture, phase counter, result capture and key cache.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      cnt           <= '0;
      key_q         <= '0;
      keylen_q      <= 1'b0;
      encdec_q      <= 1'b0;
      block_q       <= '0;
      rsp_result    <= '0;
      rsp_timeout   <= 1'b0;
      cache_valid   <= 1'b0;
      cached_key    <= '0;
      cached_keylen <= 1'b0;
    end else begin
      cnt <= (state_d != state_q) ? '0 : cnt + 1'b1;

      if ((state_q == IDLE) && req_valid) begin
        key_q       <= req_key;
        keylen_q    <= req_keylen;
        encdec_q    <= req_encdec;
        block_q     <= req_block;
        rsp_result  <= '0;
        rsp_timeout <= 1'b0;
      end

      if (state_q == RES) rsp_result[7'd127 - {idx[1:0], 5'b0} -: 32] <= aes_read_data;

      if (timeout) begin
        rsp_result  <= '0;
        rsp_timeout <= 1'b1;
      end

      if (cache_load) begin
        cached_key    <= key_q;
        cached_keylen <= keylen_q;
      end

      // A flush overrides a simultaneous load; a timeout drops the cache too.
      if (flush_key || timeout) cache_valid <= 1'b0;
      else if (cache_load)      cache_valid <= 1'b1;
    end
  end

endmodule
